// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
    typedef enum logic {PORT_IF, PORT_D} port_t;
    localparam logic [31:0] ERR_RDATA = 32'h0;
endpackage

// File: rtl/arb_priority.sv
// arb_priority: D-first pick with a starvation override that lets IF win
module arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_if,
    input  logic req_d,
    input  logic grant_fire,
    output logic grant_if,
    output logic grant_d
);
    logic [3:0] starve;
    assign grant_if = req_if & (~req_d | (starve == 4'(STARVE_LIMIT)));
    assign grant_d = req_d & ~grant_if;
    // count D wins over a waiting IF; any IF grant clears the count
    always_ff @(posedge clk or posedge rst)
        if (rst) starve <= '0;
        else if (grant_fire & grant_if) starve <= '0;
        else if (grant_fire & grant_d & req_if) starve <= starve + 4'd1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and load/store ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        if_stall,
    output logic        d_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);
    state_t     state;
    port_t      owner;
    logic [7:0] tcnt;
    logic       grant_if, grant_d, idle, misal, expire;
    assign idle = state == ST_IDLE;
    assign misal = ~d_byte & (d_addr[1:0] != 2'b00);
    assign expire = tcnt == 8'(TIMEOUT - 1);
    assign if_stall = if_req & ~if_valid;
    assign d_stall = d_req & ~d_valid;
    // a port completing this cycle is masked so its still-held req is not re-granted
    arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_pri (
        .clk(clk),
        .rst(rst),
        .req_if(if_req & ~if_valid),
        .req_d(d_req & ~d_valid),
        .grant_fire(idle),
        .grant_if(grant_if),
        .grant_d(grant_d)
    );
    // access FSM: grant and latch in IDLE, wait for ack or timeout in ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= PORT_IF;
            tcnt <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_byte <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            if_rdata <= '0;
            d_rdata <= '0;
            if_valid <= 1'b0;
            d_valid <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid <= 1'b0;
            if (idle) begin
                if (grant_d & misal) begin
                    d_valid <= 1'b1;
                    d_rdata <= ERR_RDATA;
                    bus_err <= 1'b1;
                end else if (grant_if | grant_d) begin
                    state <= ST_ACCESS;
                    mem_en <= 1'b1;
                    tcnt <= '0;
                    owner <= grant_d ? PORT_D : PORT_IF;
                    mem_addr <= grant_d ? d_addr : if_addr;
                    mem_wdata <= grant_d ? d_wdata : '0;
                    mem_we <= grant_d & d_we;
                    mem_byte <= grant_d & d_byte;
                end
            end else if (mem_ack | expire) begin
                state <= ST_IDLE;
                mem_en <= 1'b0;
                bus_err <= bus_err | ~mem_ack;
                if (owner == PORT_D) begin
                    d_valid <= 1'b1;
                    if (~mem_ack | ~mem_we) d_rdata <= mem_ack ? mem_rdata : ERR_RDATA;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_ack ? mem_rdata : ERR_RDATA;
                end
            end else begin
                tcnt <= tcnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench against a transaction-level reference model
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;
    localparam int TMO = 16;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_byte = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, if_stall, d_stall, mem_en, mem_we, mem_byte, bus_err;
    int          n_chk = 0, n_fail = 0;
    // reference model: one memory access in flight, its owner, and what each port sees next
    bit          busy, owner, la_we, la_byte, e_if_v, e_d_v, e_err;
    int          age, starve;
    logic [31:0] la_addr, la_wdata, e_if_rd, e_d_rd;
    // staged stimulus for the next cycle
    bit          s_ir, s_dr, s_we, s_by, s_ack;
    logic [31:0] s_ia, s_da, s_wd, s_rd;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .if_stall(if_stall), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 0; owner = 0; age = 0; starve = 0;
        e_if_v = 0; e_d_v = 0; e_err = 0; e_if_rd = '0; e_d_rd = '0;
    endtask

    task automatic idle_inputs();
        s_ir = 0; s_dr = 0; s_we = 0; s_by = 0; s_ack = 0;
        s_ia = '0; s_da = '0; s_wd = '0; s_rd = '0;
    endtask

    // one clock cycle: apply stimulus, compare outputs, advance the model
    task automatic step();
        bit mi, md, pick_d, nif_v, nd_v;
        @(negedge clk);
        if_req = s_ir; if_addr = s_ia; d_req = s_dr; d_we = s_we; d_byte = s_by;
        d_addr = s_da; d_wdata = s_wd; mem_ack = s_ack; mem_rdata = s_rd;
        #1;
        chk("mem_en", {31'b0, mem_en}, {31'b0, busy});
        chk("if_valid", {31'b0, if_valid}, {31'b0, e_if_v});
        chk("d_valid", {31'b0, d_valid}, {31'b0, e_d_v});
        chk("if_rdata", if_rdata, e_if_rd);
        chk("d_rdata", d_rdata, e_d_rd);
        chk("bus_err", {31'b0, bus_err}, {31'b0, e_err});
        chk("if_stall", {31'b0, if_stall}, {31'b0, s_ir & ~e_if_v});
        chk("d_stall", {31'b0, d_stall}, {31'b0, s_dr & ~e_d_v});
        if (busy) begin
            chk("mem_addr", mem_addr, la_addr);
            chk("mem_we", {31'b0, mem_we}, {31'b0, la_we});
            chk("mem_byte", {31'b0, mem_byte}, {31'b0, la_byte});
            if (owner && la_we) chk("mem_wdata", mem_wdata, la_wdata);
        end
        nif_v = 0; nd_v = 0;
        mi = s_ir && !e_if_v;
        md = s_dr && !e_d_v;
        if (busy) begin
            age++;
            if (s_ack || age == TMO) begin
                busy = 0;
                if (!s_ack) e_err = 1;
                if (owner) begin
                    nd_v = 1;
                    if (!s_ack) e_d_rd = '0;
                    else if (!la_we) e_d_rd = s_rd;
                end else begin
                    nif_v = 1;
                    e_if_rd = s_ack ? s_rd : '0;
                end
            end
        end else if (mi || md) begin
            pick_d = md && !(mi && starve == LIMIT);
            if (!pick_d) starve = 0;
            else if (mi) starve++;
            if (pick_d && !s_by && s_da[1:0] != 2'b00) begin
                nd_v = 1; e_d_rd = '0; e_err = 1;
            end else begin
                busy = 1; age = 0; owner = pick_d;
                la_addr = pick_d ? s_da : s_ia;
                la_we = pick_d && s_we;
                la_byte = pick_d && s_by;
                la_wdata = s_wd;
            end
        end
        e_if_v = nif_v; e_d_v = nd_v;
    endtask

    // one complete transfer on a port, acked on the lat-th mem_en cycle (0 = never)
    task automatic xfer(input bit is_d, input logic [31:0] a, input bit we, input bit by,
                        input logic [31:0] wd, input int lat, input logic [31:0] rd);
        bit v;
        for (int i = 0; i < 40; i++) begin
            v = is_d ? e_d_v : e_if_v;
            s_ir = !is_d; s_ia = a; s_dr = is_d; s_da = a; s_we = we; s_by = by; s_wd = wd;
            s_rd = rd; s_ack = busy && lat != 0 && age + 1 == lat;
            step();
            if (v) break;
        end
        idle_inputs();
        step();
    endtask

    task automatic reset_mid();
        #2 rst = 1'b1;
        #1;
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        if_req = 0; d_req = 0; mem_ack = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_inputs();
    endtask

    initial begin
        bit p_if, p_d, done_if, done_d, v_if, v_d, did_rst;
        int ack_pct;
        model_reset();
        idle_inputs();
        #12;
        chk("reset_mem_en", {31'b0, mem_en}, 32'd0);
        chk("reset_valids", {30'b0, if_valid, d_valid}, 32'd0);
        chk("reset_bus_err", {31'b0, bus_err}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        xfer(0, 32'h40, 0, 0, '0, 1, 32'hE3A00001);
        chk("t1_if_rdata", if_rdata, 32'hE3A00001);
        xfer(1, 32'h103, 1, 1, 32'hAB, 4, 32'h5555_AAAA);
        chk("t3_d_rdata_kept", d_rdata, 32'h0);
        xfer(1, 32'h200, 0, 0, '0, 2, 32'h1234_5678);
        xfer(1, 32'h103, 1, 1, 32'hAB, 2, 32'h0);
        chk("t3_store_keeps_rdata", d_rdata, 32'h1234_5678);
        xfer(1, 32'h102, 0, 0, '0, 1, 32'hFFFF_FFFF);
        chk("t4_bus_err", {31'b0, bus_err}, 32'd1);
        xfer(0, 32'h80, 0, 0, '0, 0, 32'hDEAD_BEEF);
        chk("t5_if_rdata_zero", if_rdata, 32'h0);
        s_ir = 1; s_ia = 32'h300;
        step();
        step();
        reset_mid();
        s_ack = 1;
        step();
        step();
        p_if = 0; p_d = 0; done_if = 0; done_d = 0; did_rst = 0;
        for (int k = 0; k < 3000; k++) begin
            ack_pct = (k >= 800 && k < 1100) ? 2 : 45;
            if (done_if) p_if = 0;
            if (done_d) p_d = 0;
            if (!p_if && !(busy && !owner) && $urandom_range(0, 3) == 0) begin
                p_if = 1; s_ia = $urandom;
            end
            if (!p_d && !(busy && owner) && $urandom_range(0, 3) == 0) begin
                p_d = 1; s_da = $urandom; s_wd = $urandom;
                if ($urandom_range(0, 3) != 0) s_da[1:0] = 2'b00;
                s_we = 1'($urandom_range(0, 1));
                s_by = 1'($urandom_range(0, 1));
            end
            if (busy && $urandom_range(0, 19) == 0) begin
                if (owner) p_d = 0;
                else p_if = 0;
            end
            s_ir = p_if; s_dr = p_d;
            s_ack = $urandom_range(0, 99) < ack_pct;
            s_rd = $urandom;
            v_if = e_if_v; v_d = e_d_v;
            step();
            done_if = v_if; done_d = v_d;
            if (!did_rst && k >= 1500 && busy) begin
                did_rst = 1;
                reset_mid();
                p_if = 0; p_d = 0; done_if = 0; done_d = 0;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
